compare_seq: RTL and testbench
==============================

Name: compare_seq

Overview:
- Sequential controller that drives a byte-wide magnitude comparator across multi-byte unsigned operands.
- Captures two NBYTES-wide words on a start pulse and walks them MSB byte first, one byte per clock, through the 8-bit compare datapath.
- Merges the per-byte results into a single 3-bit result and reports completion with a done pulse.
- Sits between a requesting unit and the shared 8-bit comparator; the comparator datapath is instantiated inside this block.

Parameters:
- NBYTES, 4, number of 8-bit bytes per operand (legal range 2..8); operand width is 8*NBYTES.

Ports:
- iClk  input  1  system clock; all state changes on the rising edge.
- iRst_n  input  1  synchronous reset, active-low, sampled on the rising edge of iClk.
- iStart  input  1  start request; honoured only in IDLE.
- iData_a  input  8*NBYTES  operand A, unsigned, sampled when start is accepted.
- iData_b  input  8*NBYTES  operand B, unsigned, sampled when start is accepted.
- oBusy  output  1  high in CMP and DONE.
- oDone  output  1  one-cycle completion pulse.
- oData  output  3  result: [2]=A>B, [1]=A==B, [0]=A<B; exactly one bit set after a completed operation.
- oByteIdx  output  3  index of the byte under compare; 0 = LSB byte.

Behaviour:
- Reset (iRst_n=0 at a rising edge):
  - state=IDLE, oBusy=0, oDone=0, oData=3'b000, oByteIdx=0.
  - Internal operand registers are cleared.
  - Reset mid-operation aborts the operation; no done pulse is produced for it.
- States: IDLE, CMP, DONE.
- IDLE:
  - If iStart=1 at edge T: latch iData_a and iData_b, set oByteIdx=NBYTES-1, clear the first-difference flag, go to CMP.
  - Otherwise stay in IDLE.
- CMP (one byte per cycle): compare byte[oByteIdx] of A against byte[oByteIdx] of B.
  - Byte differs and no earlier difference recorded: record the GT/LT result and set the flag.
  - Termination condition: oByteIdx==0, or early exit is triggered (see Optional Feature).
  - On termination: oData <= recorded result if the flag is set, else 3'b010; oDone <= 1; go to DONE.
  - Otherwise oByteIdx decrements by 1.
- DONE:
  - Lasts exactly one cycle; oDone=1 in this cycle only; next edge returns to IDLE with oDone=0.
  - oData holds its value until the next accepted start completes.
- Start handling:
  - iStart while oBusy=1 is ignored; it is not queued.
  - Operand changes after the start edge have no effect.
- Latency:
  - Start sampled at edge T; result registered at edge T+k; oDone high for cycle [T+k, T+k+1).
  - k = NBYTES with a full scan.
  - k = position of the first differing byte counted from MSB (1-based) when early exit applies.
  - Back-to-back: the earliest next start is accepted at edge T+k+2.
- Arithmetic:
  - Unsigned magnitude only.
  - Lower-byte results never override a recorded higher-byte difference.
- oData is not cleared at start; it changes only at the completion edge.

Optional Feature:
- Macro: COMPARE_SEQ_EARLY_EXIT_EN.
- Defined:
  - CMP terminates in the cycle the first differing byte is found.
  - oByteIdx freezes at that byte index through DONE.
- Undefined:
  - Always scans all NBYTES bytes; latency is fixed at k=NBYTES regardless of data (constant-time).
  - oByteIdx ends at 0.
- Result value is identical in both builds.

Test Plan (NBYTES=4):
- Reset released, no start -> oData=000, oBusy=0, oDone=0 held for 5 cycles.
- A=32'h0000_0000, B=32'h0000_0000 -> oData=010, oDone one cycle at T+4, oBusy high for 5 cycles.
- A=32'h0800_0000, B=32'h0000_0000 -> oData=100.
  - EARLY_EXIT defined: oDone at T+1, oByteIdx=3.
  - Undefined: oDone at T+4.
- A=32'hF0F0_0008, B=32'hF0F0_000F -> oData=001, oDone at T+4 in both builds (difference in LSB byte).
- A=32'h1200_00FF, B=32'h1100_0000 -> oData=100; the LSB byte (FF>00) must not override the result; a second iStart pulsed during CMP is ignored (single oDone).
- Start A=32'hFFFF_FFFF, B=32'h0000_0000, assert iRst_n=0 at T+2 -> no oDone, oData=000, state IDLE; a new start then completes normally.

Source files
------------

// File: rtl/compare_seq.sv
// -----------------------------------------------------------------------------
// compare_seq
//
// Sequential multi-byte unsigned magnitude comparator. On an accepted start
// the two operands are captured and walked MSB byte first, one byte per
// clock, through a shared 8-bit compare datapath. The per-byte outcomes are
// merged so that the most significant differing byte decides the result.
//
// Parameters:
//   NBYTES    bytes per operand (2..8); operand width is 8*NBYTES
//
// Ports:
//   iClk      in   1         system clock, rising edge
//   iRst_n    in   1         synchronous reset, active-low
//   iStart    in   1         start request, honoured only when idle
//   iData_a   in   8*NBYTES  operand A (unsigned), captured on start
//   iData_b   in   8*NBYTES  operand B (unsigned), captured on start
//   oBusy     out  1         high while comparing and in the done cycle
//   oDone     out  1         one-cycle completion pulse
//   oData     out  3         result {A>B, A==B, A<B}; held between operations
//   oByteIdx  out  3         index of the byte under compare, 0 = LSB byte
//
// Build option:
//   COMPARE_SEQ_EARLY_EXIT_EN  when defined, the scan stops at the first
//                              differing byte and oByteIdx freezes there.
//                              When undefined, every byte is always scanned
//                              so latency does not depend on the data.
// -----------------------------------------------------------------------------

// Shared 8-bit magnitude compare datapath. Exactly one output is high.
module compare_seq_cmp8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic       gt_o,
  output logic       eq_o,
  output logic       lt_o
);

  assign gt_o = (a_i > b_i);
  assign eq_o = (a_i == b_i);
  assign lt_o = (a_i < b_i);

endmodule

module compare_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iStart,
  input  logic [8*NBYTES-1:0]   iData_a,
  input  logic [8*NBYTES-1:0]   iData_b,
  output logic                  oBusy,
  output logic                  oDone,
  output logic [2:0]            oData,
  output logic [2:0]            oByteIdx
);

  localparam int          WIDTH    = 8 * NBYTES;
  localparam logic [2:0]  LAST_IDX = 3'(NBYTES - 1);
  localparam logic [2:0]  RES_EQ   = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2:0]         idx_q, idx_d;
  logic               found_q, found_d;   // a differing byte has been seen
  logic [2:0]         rec_q, rec_d;       // result from the first differing byte
  logic [2:0]         data_q, data_d;     // visible result register

  // ---------------------------------------------------------------------------
  // Byte selection. Operands are viewed as an 8-entry byte array so the 3-bit
  // index always addresses a legal entry; entries beyond NBYTES read as zero
  // and are never selected because the index starts at NBYTES-1.
  // ---------------------------------------------------------------------------
  logic [7:0][7:0] a_bytes;
  logic [7:0][7:0] b_bytes;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bytes
      if (gi < NBYTES) begin : g_used
        assign a_bytes[gi] = a_q[gi*8 +: 8];
        assign b_bytes[gi] = b_q[gi*8 +: 8];
      end else begin : g_pad
        assign a_bytes[gi] = 8'h00;
        assign b_bytes[gi] = 8'h00;
      end
    end
  endgenerate

  logic [7:0] cur_a;
  logic [7:0] cur_b;
  logic       byte_gt;
  logic       byte_eq;
  logic       byte_lt;

  assign cur_a = a_bytes[idx_q];
  assign cur_b = b_bytes[idx_q];

  compare_seq_cmp8 u_cmp8 (
    .a_i  (cur_a),
    .b_i  (cur_b),
    .gt_o (byte_gt),
    .eq_o (byte_eq),
    .lt_o (byte_lt)
  );

  logic       byte_ne;
  logic [2:0] byte_res;
  logic       last_byte;
  logic       terminate;

  assign byte_ne   = ~byte_eq;
  assign byte_res  = {byte_gt, 1'b0, byte_lt};
  assign last_byte = (idx_q == 3'd0);

`ifdef COMPARE_SEQ_EARLY_EXIT_EN
  // Any difference seen here is necessarily the first one: an earlier
  // difference would already have ended the scan.
  assign terminate = last_byte | byte_ne;
`else
  assign terminate = last_byte;
`endif

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    found_d = found_q;
    rec_d   = rec_q;
    data_d  = data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          a_d     = iData_a;
          b_d     = iData_b;
          idx_d   = LAST_IDX;
          found_d = 1'b0;
          rec_d   = 3'b000;
          state_d = ST_CMP;
        end
      end

      ST_CMP: begin
        // Only the most significant difference is kept; lower bytes are
        // still visited in the constant-time build but cannot override it.
        if (byte_ne && !found_q) begin
          found_d = 1'b1;
          rec_d   = byte_res;
        end

        if (terminate) begin
          // The recorded flag lags by one cycle, so a difference found in
          // this very cycle is taken straight from the comparator.
          if (found_q) begin
            data_d = rec_q;
          end else if (byte_ne) begin
            data_d = byte_res;
          end else begin
            data_d = RES_EQ;
          end
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - 3'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= 3'd0;
      found_q <= 1'b0;
      rec_q   <= 3'b000;
      data_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      found_q <= found_d;
      rec_q   <= rec_d;
      data_q  <= data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. The done pulse is the single cycle spent in ST_DONE, which is
  // entered on the same edge that registers the result.
  // ---------------------------------------------------------------------------
  assign oBusy    = (state_q == ST_CMP) || (state_q == ST_DONE);
  assign oDone    = (state_q == ST_DONE);
  assign oData    = data_q;
  assign oByteIdx = idx_q;

endmodule

// File: tb/tb_compare_seq.sv
// -----------------------------------------------------------------------------
// tb_compare_seq
//
// Self-checking bench for compare_seq with NBYTES=4. Expected results come
// from whole-word unsigned comparison; expected latency and final byte index
// come from locating the most significant differing byte.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_compare_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic          iClk;
  logic          iRst_n;
  logic          iStart;
  logic [W-1:0]  iData_a;
  logic [W-1:0]  iData_b;
  logic          oBusy;
  logic          oDone;
  logic [2:0]    oData;
  logic [2:0]    oByteIdx;

  int errors = 0;
  int checks = 0;
  logic [2:0] last_res = 3'b000;

  compare_seq #(.NBYTES(NB)) dut (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .iStart   (iStart),
    .iData_a  (iData_a),
    .iData_b  (iData_b),
    .oBusy    (oBusy),
    .oDone    (oDone),
    .oData    (oData),
    .oByteIdx (oByteIdx)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [2:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a > b)       return 3'b100;
    else if (a == b) return 3'b010;
    else             return 3'b001;
  endfunction

  // Index of the most significant differing byte, -1 if the words are equal.
  function automatic int first_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = NB - 1; i >= 0; i--) begin
      if (((a >> (8 * i)) & 32'hFF) != ((b >> (8 * i)) & 32'hFF)) return i;
    end
    return -1;
  endfunction

  function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef COMPARE_SEQ_EARLY_EXIT_EN
    int d;
    d = first_diff(a, b);
    if (d >= 0) return NB - d;
`endif
    return NB;
  endfunction

  function automatic logic [2:0] ref_idx(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef COMPARE_SEQ_EARLY_EXIT_EN
    int d;
    d = first_diff(a, b);
    if (d >= 0) return 3'(d);
`endif
    return 3'd0;
  endfunction

  // ---------------------------------------------------------------------------
  // Run one operation and observe it (no comparisons here).
  // c counts cycles after the accepting edge T; samples are at negedges.
  // ---------------------------------------------------------------------------
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] prev, input bit poke,
                       output int lat, output int dones, output int busy,
                       output logic [2:0] res, output logic [2:0] idx,
                       output int early_change);
    @(negedge iClk);
    iStart  = 1'b1;
    iData_a = a;
    iData_b = b;
    @(posedge iClk);
    lat = 0; dones = 0; busy = 0; early_change = 0; res = 3'b000; idx = 3'd0;
    for (int c = 0; c < NB + 6; c++) begin
      @(negedge iClk);
      if (c == 0) begin
        iStart  = 1'b0;
        iData_a = W'($urandom);
        iData_b = W'($urandom);
      end
      if (oBusy) busy++;
      if (oDone) begin
        dones++;
        if (lat == 0) begin
          lat = c;
          res = oData;
          idx = oByteIdx;
        end
      end else if (lat == 0 && oData !== prev) begin
        early_change++;
      end
      if (poke && c == 1) iStart = 1'b1;
      if (poke && c == 2) iStart = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    iRst_n  = 1'b0;
    iStart  = 1'b0;
    iData_a = '0;
    iData_b = '0;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    iRst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge iClk);
      checks++;
      if (oData !== 3'b000) begin
        errors++;
        $display("FAIL reset_data cycle=%0d got=%b want=000", c, oData);
      end
      checks++;
      if (oBusy !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy cycle=%0d got=%b want=0", c, oBusy);
      end
      checks++;
      if (oDone !== 1'b0) begin
        errors++;
        $display("FAIL reset_done cycle=%0d got=%b want=0", c, oDone);
      end
    end
    checks++;
    if (oByteIdx !== 3'd0) begin
      errors++;
      $display("FAIL reset_idx got=%0d want=0", oByteIdx);
    end
    $display("test_reset: idle outputs observed for 5 cycles");
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [4];
    logic [W-1:0] tb [4];
    bit           tp [4];
    int lat, dones, busy, early;
    logic [2:0] res, idx, eres, eidx;
    int elat;
    ta[0] = 32'h0000_0000; tb[0] = 32'h0000_0000; tp[0] = 1'b0;
    ta[1] = 32'h0800_0000; tb[1] = 32'h0000_0000; tp[1] = 1'b0;
    ta[2] = 32'hF0F0_0008; tb[2] = 32'hF0F0_000F; tp[2] = 1'b0;
    ta[3] = 32'h1200_00FF; tb[3] = 32'h1100_0000; tp[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], last_res, tp[i], lat, dones, busy, res, idx, early);
      eres = ref_res(ta[i], tb[i]);
      elat = ref_lat(ta[i], tb[i]);
      eidx = ref_idx(ta[i], tb[i]);
      $display("directed[%0d] A=%h B=%h poke=%0d -> data=%b lat=%0d idx=%0d dones=%0d busy=%0d",
               i, ta[i], tb[i], tp[i], res, lat, idx, dones, busy);
      checks++;
      if (res !== eres) begin
        errors++;
        $display("FAIL dir_data[%0d] got=%b want=%b", i, res, eres);
      end
      checks++;
      if (lat !== elat) begin
        errors++;
        $display("FAIL dir_latency[%0d] got=%0d want=%0d", i, lat, elat);
      end
      checks++;
      if (dones !== 1) begin
        errors++;
        $display("FAIL dir_done_count[%0d] got=%0d want=1", i, dones);
      end
      checks++;
      if (busy !== elat + 1) begin
        errors++;
        $display("FAIL dir_busy_cycles[%0d] got=%0d want=%0d", i, busy, elat + 1);
      end
      checks++;
      if (idx !== eidx) begin
        errors++;
        $display("FAIL dir_byteidx[%0d] got=%0d want=%0d", i, idx, eidx);
      end
      checks++;
      if (early !== 0) begin
        errors++;
        $display("FAIL dir_data_early_change[%0d] got=%0d want=0", i, early);
      end
      last_res = eres;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    int lat, dones, busy, early, pos, elat;
    logic [2:0] res, idx, eres, eidx;
    for (int i = 0; i < 30; i++) begin
      a = W'($urandom);
      b = a;
      if ($urandom_range(0, 4) != 0) begin
        pos = $urandom_range(0, NB - 1);
        b[pos*8 +: 8] = 8'($urandom);
        if ($urandom_range(0, 1) == 1) b[7:0] = 8'($urandom);
      end
      do_op(a, b, last_res, 1'b0, lat, dones, busy, res, idx, early);
      eres = ref_res(a, b);
      elat = ref_lat(a, b);
      eidx = ref_idx(a, b);
      $display("random[%0d] A=%h B=%h -> data=%b lat=%0d idx=%0d", i, a, b, res, lat, idx);
      checks++;
      if (res !== eres || lat !== elat || idx !== eidx || dones !== 1 || busy !== elat + 1 || early !== 0) begin
        errors++;
        $display("FAIL rand[%0d] got data=%b lat=%0d idx=%0d dones=%0d busy=%0d early=%0d want data=%b lat=%0d idx=%0d dones=1 busy=%0d early=0",
                 i, res, lat, idx, dones, busy, early, eres, elat, eidx, elat + 1);
      end
      last_res = eres;
    end
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] a, b;
    int lat, dones, busy, early, seen;
    logic [2:0] res, idx;
    a = 32'hFFFF_FFFF;
`ifdef COMPARE_SEQ_EARLY_EXIT_EN
    b = 32'hFFFF_FF00;   // keeps the operation running past T+2
`else
    b = 32'h0000_0000;
`endif
    seen = 0;
    @(negedge iClk);
    iStart  = 1'b1;
    iData_a = a;
    iData_b = b;
    @(posedge iClk);           // T
    @(negedge iClk);
    iStart = 1'b0;
    if (oDone) seen++;
    @(negedge iClk);           // after T+1
    if (oDone) seen++;
    iRst_n = 1'b0;             // sampled at T+2
    @(negedge iClk);
    checks++;
    if (oBusy !== 1'b0 || oDone !== 1'b0 || oData !== 3'b000 || oByteIdx !== 3'd0) begin
      errors++;
      $display("FAIL abort_outputs got busy=%b done=%b data=%b idx=%0d want busy=0 done=0 data=000 idx=0",
               oBusy, oDone, oData, oByteIdx);
    end
    iRst_n = 1'b1;
    for (int c = 0; c < NB + 4; c++) begin
      @(negedge iClk);
      if (oDone || oBusy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_done got=%0d busy/done cycles want=0", seen);
    end
    $display("reset_abort A=%h B=%h -> busy/done cycles after start=%0d", a, b, seen);
    last_res = 3'b000;
    a = 32'h0000_1234;
    b = 32'h0000_1235;
    do_op(a, b, last_res, 1'b0, lat, dones, busy, res, idx, early);
    $display("after_abort A=%h B=%h -> data=%b lat=%0d", a, b, res, lat);
    checks++;
    if (res !== ref_res(a, b) || lat !== ref_lat(a, b) || dones !== 1) begin
      errors++;
      $display("FAIL after_abort got data=%b lat=%0d dones=%0d want data=%b lat=%0d dones=1",
               res, lat, dones, ref_res(a, b), ref_lat(a, b));
    end
    last_res = ref_res(a, b);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2;
    int lat1, lat2;
    logic [2:0] r2;
    a1 = 32'h0000_0001; b1 = 32'h0000_0002;
    a2 = 32'h8000_0000; b2 = 32'h7FFF_FFFF;
    lat1 = 0; lat2 = 0; r2 = 3'b000;
    @(negedge iClk);
    iStart = 1'b1; iData_a = a1; iData_b = b1;
    @(posedge iClk);
    @(negedge iClk);
    iStart = 1'b0;
    for (int c = 1; c < NB + 6 && lat1 == 0; c++) begin
      @(negedge iClk);
      if (oDone) lat1 = c;
    end
    checks++;
    if (lat1 !== ref_lat(a1, b1)) begin
      errors++;
      $display("FAIL b2b_first_latency got=%0d want=%0d", lat1, ref_lat(a1, b1));
    end
    // Hold start from the done cycle on; the DONE-state edge must ignore it
    // and the following edge must accept it.
    iStart = 1'b1; iData_a = a2; iData_b = b2;
    @(negedge iClk);           // after T+k+1: idle, not yet accepted
    checks++;
    if (oBusy !== 1'b0 || oDone !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap got busy=%b done=%b want busy=0 done=0", oBusy, oDone);
    end
    @(negedge iClk);           // after T+k+2: accepted
    iStart = 1'b0;
    checks++;
    if (oBusy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept got busy=%b want=1", oBusy);
    end
    for (int c = 1; c < NB + 6 && lat2 == 0; c++) begin
      @(negedge iClk);
      if (oDone) begin
        lat2 = c;
        r2   = oData;
      end
    end
    $display("back_to_back op1 lat=%0d op2 A=%h B=%h -> data=%b lat=%0d", lat1, a2, b2, r2, lat2);
    checks++;
    if (r2 !== ref_res(a2, b2) || lat2 !== ref_lat(a2, b2)) begin
      errors++;
      $display("FAIL b2b_second got data=%b lat=%0d want data=%b lat=%0d",
               r2, lat2, ref_res(a2, b2), ref_lat(a2, b2));
    end
    last_res = ref_res(a2, b2);
    repeat (2) @(negedge iClk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
